// File: rtl/byte_pack_loader_if.sv
// Byte stream handshake bundle for byte_pack_loader.
// Ports: s_valid_i, s_data_i, s_last_i from source; s_ready_o from loader.
interface byte_pack_loader_if #(
    parameter int IN_DATA_WIDTH = 8
);
    logic                     s_valid_i;
    logic                     s_ready_o;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_last_i;

    modport master (
        output s_valid_i,
        output s_data_i,
        output s_last_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  s_last_i,
        output s_ready_o
    );
endinterface

// File: rtl/byte_pack_loader.sv
// Packs a byte stream MSB-first into BRAM0 words, then kicks the accumulator.
// Ports: clk/reset, load_start_i, s (byte stream), BRAM0 write bus, run/status.
module byte_pack_loader #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int CNT_BIT       = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start_i,
    byte_pack_loader_if.slave  s,
    output logic [AWIDTH-1:0]  addr_b0_o,
    output logic               ce_b0_o,
    output logic               we_b0_o,
    output logic [DWIDTH-1:0]  d_b0_o,
    output logic               start_run_o,
    output logic [CNT_BIT-1:0] run_count_o,
    input  logic               acc_done_i,
    output logic               idle_o,
    output logic               load_o,
    output logic               done_o,
    output logic               trunc_o
);
    localparam int LANES = DWIDTH / IN_DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      lane_q;
    logic [DWIDTH-1:0]  pack_q, pack_d;
    logic [DWIDTH-1:0]  w_word_q;
    logic               wr_q;
    logic               end_q;
    logic               trunc_q;
    logic [CNT_BIT-1:0] row_q;
    logic               last_row;
    logic               word_full;
    logic               ready;
    logic               accept;
    int                 lane_base;

    assign last_row  = (row_q == CNT_BIT'(MEM_SIZE - 1));
    assign word_full = (lane_q == LW'(LANES - 1));

    // Stop taking bytes once the frame end is seen, and while the final
    // row is being written so nothing slips past a full memory.
    assign ready  = (state_q == LOAD) && !end_q && !(wr_q && last_row);
    assign accept = s.s_valid_i && ready;

    assign s.s_ready_o = ready;

    // First byte lands in the top lane.
    always_comb begin
        pack_d    = pack_q;
        lane_base = (LANES - 1 - int'(lane_q)) * IN_DATA_WIDTH;
        pack_d[lane_base +: IN_DATA_WIDTH] = s.s_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_run_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start_i) state_d = LOAD;
            end
            LOAD: begin
                if (wr_q && (end_q || last_row)) state_d = START;
            end
            START: begin
                start_run_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (acc_done_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q   <= '0;
            pack_q   <= '0;
            w_word_q <= '0;
            wr_q     <= 1'b0;
            end_q    <= 1'b0;
            trunc_q  <= 1'b0;
            row_q    <= '0;
        end else begin
            wr_q <= 1'b0;
            if (state_q == IDLE && load_start_i) begin
                row_q   <= '0;
                lane_q  <= '0;
                pack_q  <= '0;
                trunc_q <= 1'b0;
                end_q   <= 1'b0;
            end
            if (wr_q) begin
                row_q <= row_q + CNT_BIT'(1);
                if (!end_q && last_row) trunc_q <= 1'b1;
            end
            if (accept) begin
                if (word_full || s.s_last_i) begin
                    wr_q     <= 1'b1;
                    w_word_q <= pack_d;
                    pack_q   <= '0;
                    lane_q   <= '0;
                end else begin
                    pack_q <= pack_d;
                    lane_q <= lane_q + LW'(1);
                end
                if (s.s_last_i) end_q <= 1'b1;
            end
        end
    end

    assign ce_b0_o     = wr_q;
    assign we_b0_o     = wr_q;
    assign addr_b0_o   = wr_q ? row_q[AWIDTH-1:0] : '0;
    assign d_b0_o      = wr_q ? w_word_q : '0;
    assign run_count_o = row_q;
    assign trunc_o     = trunc_q;
    assign idle_o      = (state_q == IDLE);
    assign load_o      = (state_q == LOAD);
    assign done_o      = (state_q == DONE);
endmodule

// File: tb/tb_byte_pack_loader.sv
// Randomized bench for byte_pack_loader against a byte-list memory model.
// Drives frames through the stream interface and scores BRAM0 writes.
module tb_byte_pack_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_start_i;
    logic [7:0]  addr_b0_o;
    logic        ce_b0_o;
    logic        we_b0_o;
    logic [31:0] d_b0_o;
    logic        start_run_o;
    logic [30:0] run_count_o;
    logic        acc_done_i;
    logic        idle_o;
    logic        load_o;
    logic        done_o;
    logic        trunc_o;

    byte_pack_loader_if #(.IN_DATA_WIDTH(8)) bus ();

    byte_pack_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start_i (load_start_i),
        .s            (bus),
        .addr_b0_o    (addr_b0_o),
        .ce_b0_o      (ce_b0_o),
        .we_b0_o      (we_b0_o),
        .d_b0_o       (d_b0_o),
        .start_run_o  (start_run_o),
        .run_count_o  (run_count_o),
        .acc_done_i   (acc_done_i),
        .idle_o       (idle_o),
        .load_o       (load_o),
        .done_o       (done_o),
        .trunc_o      (trunc_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  tx [0:1535];
    logic [7:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          start_cnt = 0;
    logic [30:0] start_rc;
    logic        start_tr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ce_b0_o && we_b0_o) begin
            wa_q.push_back(addr_b0_o);
            wd_q.push_back(d_b0_o);
        end
        if (start_run_o) begin
            start_cnt++;
            start_rc = run_count_o;
            start_tr = trunc_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 continuous, 1 valid toggles every cycle, 2 random gaps
    task automatic run_frame(input int n, input bit has_last,
                             input int mode, input bit pre_pulse);
        int          exp_acc;
        int          rows;
        int          idx;
        int          stall;
        int          cyc;
        int          sc0;
        bit          v;
        logic [31:0] exp_w [0:255];

        exp_acc = (n > 1024) ? 1024 : n;
        rows    = (exp_acc + 3) / 4;
        for (int r = 0; r < 256; r++) exp_w[r] = 32'h0;
        for (int i = 0; i < exp_acc; i++)
            exp_w[i / 4] = exp_w[i / 4] | (32'(tx[i]) << (24 - 8 * (i % 4)));

        wa_q.delete();
        wd_q.delete();
        sc0 = start_cnt;

        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        check("enter_load", load_o, 1);

        if (pre_pulse) begin
            acc_done_i = 1'b1;
            tick();
            acc_done_i = 1'b0;
            check("done_ign_load", {load_o, done_o}, 2'b10);
        end

        idx   = 0;
        stall = 0;
        cyc   = 0;
        while (idx < n && stall < 8 && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0] == 1'b0;
                default: v = $urandom_range(99) >= 40;
            endcase
            bus.s_valid_i = v;
            bus.s_data_i  = tx[idx];
            bus.s_last_i  = has_last && (idx == n - 1);
            @(negedge clk);
            if (v && bus.s_ready_o) begin
                idx++;
                stall = 0;
            end else if (v) begin
                stall++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;

        check("accepted", idx, exp_acc);
        if (!has_last) check("ready_after_full", bus.s_ready_o, 0);

        for (int c = 0; c < 20 && start_cnt == sc0; c++) tick();
        check("start_pulses", start_cnt - sc0, 1);
        check("run_count", start_rc, rows);
        check("trunc", start_tr, !has_last);

        check("n_writes", wa_q.size(), rows);
        for (int r = 0; r < rows && r < wa_q.size(); r++) begin
            check($sformatf("addr%0d", r), wa_q[r], r);
            check($sformatf("data%0d", r), wd_q[r], exp_w[r]);
        end

        tick();
        check("wait_state", {idle_o, load_o, done_o, start_run_o}, 4'b0000);
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        check("ls_ign_wait", {idle_o, load_o}, 2'b00);
        acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        check("done_pulse", {done_o, idle_o}, 2'b10);
        tick();
        check("back_idle", {done_o, idle_o}, 2'b01);
        check("rc_hold", run_count_o, rows);
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        load_start_i  = 1'b0;
        acc_done_i    = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h0;
        bus.s_last_i  = 1'b0;
        repeat (3) tick();
        check("rst_status", {idle_o, load_o, done_o, trunc_o}, 4'b1000);
        check("rst_bus", {ce_b0_o, we_b0_o, start_run_o, bus.s_ready_o}, 0);
        check("rst_count", run_count_o, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) tx[i] = 8'(i + 1);
        run_frame(8, 1'b1, 0, 1'b1);

        for (int i = 0; i < 5; i++) tx[i] = 8'(8'hA1 + i);
        run_frame(5, 1'b1, 0, 1'b0);

        for (int i = 0; i < 13; i++) tx[i] = 8'($urandom);
        run_frame(13, 1'b1, 0, 1'b0);
        run_frame(13, 1'b1, 1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(40, 1);
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            run_frame(n, 1'b1, 2, 1'b0);
        end

        for (int i = 0; i < 1030; i++) tx[i] = 8'($urandom);
        run_frame(1030, 1'b0, 0, 1'b0);

        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        bus.s_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.s_data_i = 8'(8'h60 + i);
            tick();
        end
        bus.s_valid_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_status", {idle_o, load_o, done_o, trunc_o}, 4'b1000);
        check("mid_rst_bus", {ce_b0_o, start_run_o, bus.s_ready_o}, 0);
        check("mid_rst_count", run_count_o, 0);
        tick();

        tx[0] = 8'hC1;
        tx[1] = 8'hC2;
        tx[2] = 8'hC3;
        tx[3] = 8'hC4;
        run_frame(4, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/byte_pack_loader.md
BYTE_PACK_LOADER -- requirements
Module: byte_pack_loader

Parameters
REQ-001 SHALL have IN_DATA_WIDTH, default 8, byte lane width.
REQ-002 SHALL have DWIDTH, default 32, BRAM0 word width (4 lanes).
REQ-003 SHALL have AWIDTH, default 8, BRAM0 address width.
REQ-004 SHALL have MEM_SIZE, default 256, BRAM0 depth in rows.
REQ-005 SHALL have CNT_BIT, default 31, row-count width.

Interface
REQ-006 SHALL have clk, input, 1, single clock; all logic on posedge.
REQ-007 SHALL have reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have load_start_i, input, 1, pulse that opens a frame.
REQ-009 SHALL have s_valid_i, input, 1, byte valid.
REQ-010 SHALL have s_ready_o, output, 1, byte ready.
REQ-011 SHALL have s_data_i, input, IN_DATA_WIDTH, byte payload.
REQ-012 SHALL have s_last_i, input, 1, final byte of frame.
REQ-013 SHALL have addr_b0_o, output, AWIDTH, BRAM0 address.
REQ-014 SHALL have ce_b0_o / we_b0_o, output, 1 each, BRAM0 chip/write enable.
REQ-015 SHALL have d_b0_o, output, DWIDTH, BRAM0 write data.
REQ-016 SHALL have start_run_o, output, 1, pulse to downstream accumulator stage.
REQ-017 SHALL have run_count_o, output, CNT_BIT, rows written, valid with start_run_o.
REQ-018 SHALL have acc_done_i, input, 1, downstream done pulse.
REQ-019 SHALL have idle_o, load_o, done_o, trunc_o, output, 1 each, status.

Function
REQ-020 SHALL implement FSM IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE.
REQ-021 IDLE: on load_start_i, clear row counter, lane index and trunc_o; go LOAD next cycle.
REQ-022 Byte transfer occurs only when s_valid_i && s_ready_o; s_ready_o SHALL be 1 only in LOAD and not in the cycle after frame end is accepted.
REQ-023 Packing: 1st accepted byte -> d[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-024 Write: cycle after 4th byte accepted, ce_b0_o=we_b0_o=1 for exactly one cycle, addr_b0_o=row counter, d_b0_o=packed word; row counter +1 after write.
REQ-025 Back-to-back bytes SHALL be accepted at 1/cycle with no bubbles across word boundaries.
REQ-026 Partial word: s_last_i on lane 1..3 SHALL write packed word with unfilled lower lanes = 0, then go START.
REQ-027 s_last_i on lane 4 SHALL write normally, then go START.
REQ-028 Full: write to row MEM_SIZE-1 without s_last_i SHALL end the frame (go START), set trunc_o=1; further bytes not accepted.
REQ-029 START: start_run_o=1 one cycle, run_count_o = rows written (1..MEM_SIZE); run_count_o holds until next load_start_i.
REQ-030 WAIT: hold until acc_done_i; then DONE one cycle (done_o=1), then IDLE.
REQ-031 load_start_i outside IDLE SHALL be ignored; acc_done_i outside WAIT SHALL be ignored.
REQ-032 ce_b0_o=we_b0_o=0 whenever no write is issued; BRAM0 never read by this block.
REQ-033 Status: idle_o=(IDLE), load_o=(LOAD), done_o=(DONE).

Reset
REQ-034 reset=1 at any clk edge, including mid-frame, SHALL force IDLE, all counters/packing registers 0, all outputs 0 except idle_o=1; partial word discarded.

Verification
REQ-035 8 bytes 0x01..0x08, last on 0x08 -> writes addr0=0x01020304, addr1=0x05060708; start_run_o pulse, run_count_o=2.
REQ-036 5 bytes 0xA1..0xA5, last on 0xA5 -> addr1=0xA5000000, run_count_o=2, trunc_o=0.
REQ-037 1024+ bytes no last -> 256 writes addr 0..255, trunc_o=1, run_count_o=256, s_ready_o=0 after.
REQ-038 s_valid_i toggling 1/0 each cycle -> same memory image as continuous stream; no duplicate or dropped bytes.
REQ-039 reset asserted after 6 bytes, then new 4-byte frame -> single write addr0 with new frame data, run_count_o=1.
REQ-040 acc_done_i pulsed in LOAD then in WAIT -> only the WAIT pulse yields done_o one cycle, then idle_o=1.
